// File: rtl/ternary_sched_pkg.sv
// Shared types and constants for the ternary multiplier scheduler.
// Optional feature macro used by the top: TERNARY_SCHED_PERF_EN.
package ternary_pkg;

    // Default configuration: 14-element inputs, 7 output rows,
    // 2-bit weights packed into 16-bit load beats.
    localparam int DEF_MAX_IN_LEN  = 14;
    localparam int DEF_MAX_OUT_LEN = 7;
    localparam int DEF_LOAD_BEATS  = 13;
    localparam int DEF_PIPE_LAT    = 1;

    // Command opcodes carried on cmd_op.
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MWAIT = 3'd2,
        ST_MULT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Beats needed to stream a full ternary weight matrix (2 bits/weight).
    function automatic int beats_for(input int in_len, input int out_len);
        return (2 * in_len * out_len + 15) / 16;
    endfunction

endpackage

// File: rtl/ternary_sched_if.sv
// Command and input-beat handshake bundle for ternary_sched.
// master = command/data source, slave = scheduler.
interface ternary_sched_if;
    logic cmd_valid;
    logic cmd_op;
    logic cmd_ready;
    logic in_valid;
    logic in_ready;

    modport master (
        output cmd_valid, cmd_op, in_valid,
        input  cmd_ready, in_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid,
        output cmd_ready, in_ready
    );
endinterface

// File: rtl/ternary_sched_vdly.sv
// Fixed-latency valid delay line matching the multiplier result latency.
module ternary_sched_vdly #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    output logic out_vld
);

    logic [LAT-1:0] vld_pipe;

    // Shift the enable through LAT flops; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[LAT-1];

endmodule

// File: rtl/ternary_sched.sv
// Ternary multiplier scheduler: sequences weight loads and per-vector
// multiply passes over MAX_OUT_LEN rows, then drains the result pipeline.
// Optional: define TERNARY_SCHED_PERF_EN to add a saturating perf_cnt of
// completed multiply vectors.
module ternary_sched
    import ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = DEF_MAX_IN_LEN,
    parameter int MAX_OUT_LEN = DEF_MAX_OUT_LEN,
    parameter int LOAD_BEATS  = DEF_LOAD_BEATS,
    parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    ternary_sched_if.slave    bus,
    output logic              load_en,
    output logic [3:0]        load_idx,
    output logic              mult_en,
    output logic [2:0]        row,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              weights_ok
`ifdef TERNARY_SCHED_PERF_EN
   ,output logic [15:0]       perf_cnt
`endif
);

    // A weight beat count that cannot hold the matrix is a build error.
    if (LOAD_BEATS != beats_for(MAX_IN_LEN, MAX_OUT_LEN)) begin : g_cfg_err
        $error("ternary_sched: LOAD_BEATS does not match MAX_IN_LEN x MAX_OUT_LEN");
    end

    state_t     state, state_nxt;
    logic [2:0] drain_cnt;
    logic       cmd_rdy, in_rdy;
    logic       cmd_fire, beat_fire;
    logic       load_last, row_last, drain_last;

    assign cmd_fire   = bus.cmd_valid && cmd_rdy;
    assign beat_fire  = bus.in_valid && in_rdy;
    assign load_last  = (load_idx  == 4'(LOAD_BEATS - 1));
    assign row_last   = (row       == 3'(MAX_OUT_LEN - 1));
    assign drain_last = (drain_cnt == 3'(PIPE_LAT - 1));

    assign bus.cmd_ready = cmd_rdy;
    assign bus.in_ready  = in_rdy;
    assign busy          = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        in_rdy    = 1'b0;
        load_en   = 1'b0;
        mult_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_fire) begin
                    if (bus.cmd_op == OP_LOAD) state_nxt = ST_LOAD;
                    else if (weights_ok)       state_nxt = ST_MWAIT;
                end
            end
            ST_LOAD: begin
                in_rdy  = 1'b1;
                load_en = bus.in_valid;
                if (beat_fire && load_last) state_nxt = ST_IDLE;
            end
            ST_MWAIT: begin
                in_rdy = 1'b1;
                if (beat_fire) state_nxt = ST_MULT;
            end
            ST_MULT: begin
                mult_en = 1'b1;
                if (row_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index counters, weight-resident flag and completion/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_idx   <= '0;
            row        <= '0;
            drain_cnt  <= '0;
            weights_ok <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (bus.cmd_op == OP_LOAD) begin
                            load_idx   <= '0;
                            weights_ok <= 1'b0;
                        end else if (!weights_ok) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat_fire) begin
                        if (load_last) begin
                            weights_ok <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            load_idx <= load_idx + 4'd1;
                        end
                    end
                end
                ST_MWAIT: begin
                    if (beat_fire) row <= '0;
                end
                ST_MULT: begin
                    drain_cnt <= '0;
                    if (!row_last) row <= row + 3'd1;
                end
                ST_DRAIN: begin
                    if (drain_last) done <= 1'b1;
                    else            drain_cnt <= drain_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    ternary_sched_vdly #(.LAT(PIPE_LAT)) u_vdly (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (mult_en),
        .out_vld (out_valid)
    );

`ifdef TERNARY_SCHED_PERF_EN
    // Count finished multiply vectors, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            perf_cnt <= '0;
        else if (state == ST_DRAIN && drain_last && perf_cnt != 16'hFFFF)
            perf_cnt <= perf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ternary_sched.sv
// Directed bench for ternary_sched at default parameters (PIPE_LAT=1).
module tb_ternary_sched;
    import ternary_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en, mult_en, out_valid, busy, done, err, weights_ok;
    logic [3:0] load_idx;
    logic [2:0] row;
`ifdef TERNARY_SCHED_PERF_EN
    logic [15:0] perf_cnt;
`endif

    ternary_sched_if bus ();

    ternary_sched dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .load_en    (load_en),
        .load_idx   (load_idx),
        .mult_en    (mult_en),
        .row        (row),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .weights_ok (weights_ok)
`ifdef TERNARY_SCHED_PERF_EN
       ,.perf_cnt   (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Strobe counters and an independent 1-cycle mult_en delay model.
    int n_load_en = 0, n_mult_en = 0, n_outv = 0, n_done = 0, n_errp = 0;
    int n_outv_bad = 0;
    bit mon_en = 1'b0;
    bit mult_d = 1'b0;

    always @(posedge clk) begin
        if (mon_en) begin
            if (load_en)   n_load_en <= n_load_en + 1;
            if (mult_en)   n_mult_en <= n_mult_en + 1;
            if (out_valid) n_outv    <= n_outv + 1;
            if (done)      n_done    <= n_done + 1;
            if (err)       n_errp    <= n_errp + 1;
            if (out_valid !== mult_d) n_outv_bad <= n_outv_bad + 1;
        end
        mult_d <= rst ? 1'b0 : (mult_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with optional single-cycle in_valid gaps at cycle indices ga/gb.
    task automatic run_load(input int ga, input int gb, input int exp_cyc);
        int beat, c, l0;
        l0 = n_load_en;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        tick();
        bus.cmd_valid = 1'b0;
        #1 chk("load_wok_clr", weights_ok, 0);
        beat = 0;
        c = 0;
        while (beat < 13 && c < 40) begin
            bus.in_valid = (c != ga && c != gb);
            #1;
            chk("load_idx", load_idx, beat);
            chk("load_en", load_en, bus.in_valid);
            tick();
            if (bus.in_valid) beat++;
            c++;
        end
        bus.in_valid = 1'b0;
        #1;
        chk("load_cycles", c, exp_cyc);
        chk("load_done", done, 1);
        chk("load_wok", weights_ok, 1);
        chk("load_busy", busy, 0);
        chk("load_en_cnt", n_load_en - l0, 13);
        tick();
        chk("load_done_pulse", done, 0);
    endtask

    // One multiply; keep_cmd leaves cmd_valid high for the whole pass.
    task automatic run_mult(input bit keep_cmd);
        int m0, o0;
        m0 = n_mult_en;
        o0 = n_outv;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MULT;
        #1 chk("mul_cmd_rdy", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = keep_cmd;
        #1;
        chk("mwait_in_rdy", bus.in_ready, 1);
        chk("mwait_cmd_rdy", bus.cmd_ready, 0);
        chk("mwait_mult_en", mult_en, 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 7; r++) begin
            #1;
            chk("mult_en", mult_en, 1);
            chk("mult_row", row, r);
            chk("mult_outv", out_valid, (r > 0) ? 1 : 0);
            chk("mult_cmd_rdy", bus.cmd_ready, 0);
            chk("mult_in_rdy", bus.in_ready, 0);
            tick();
        end
        #1;
        chk("drain_mult_en", mult_en, 0);
        chk("drain_outv", out_valid, 1);
        chk("drain_done", done, 0);
        chk("drain_row", row, 6);
        tick();
        #1;
        chk("mul_done", done, 1);
        chk("mul_busy", busy, 0);
        chk("mul_outv_off", out_valid, 0);
        chk("mul_en_cnt", n_mult_en - m0, 7);
        chk("mul_outv_cnt", n_outv - o0, 7);
    endtask

    initial begin
        int d0, e0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.in_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("rst_cmd_rdy", bus.cmd_ready, 1);
        chk("rst_in_rdy", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wok", weights_ok, 0);
        chk("rst_idx", load_idx, 0);
        chk("rst_row", row, 0);
        chk("rst_strobes", {load_en, mult_en, out_valid, done, err}, 0);
        tick();

        // Multiply with no weights: one err pulse, stays idle.
        d0 = n_done;
        e0 = n_errp;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MULT;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        chk("noload_err", err, 1);
        chk("noload_busy", busy, 0);
        tick();
        tick();
        chk("noload_err_cnt", n_errp - e0, 1);
        chk("noload_done_cnt", n_done - d0, 0);

        // Continuous load, then gapped load (two cycles longer).
        run_load(-1, -1, 13);
        run_load(4, 10, 15);

        // Single multiply, then held-command back-to-back pair.
        run_mult(1'b0);
        tick();
        run_mult(1'b1);
        run_mult(1'b0);
        tick();

        // Reset while at row 3 aborts the pass.
        d0 = n_done;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MULT;
        tick();
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        for (int r = 0; r < 3; r++) tick();
        #1 chk("abort_row", row, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wok", weights_ok, 0);
        chk("abort_row_clr", row, 0);
        chk("abort_outv", out_valid, 0);
        tick();
        tick();
        chk("abort_no_done", n_done - d0, 0);
        e0 = n_errp;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MULT;
        tick();
        bus.cmd_valid = 1'b0;
        #1 chk("abort_err", err, 1);
        tick();
        tick();
        chk("abort_err_cnt", n_errp - e0, 1);
        chk("outv_delay", n_outv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ternary_sched.md
TERNARY_SCHED -- requirements
Module: ternary_sched

Interface
REQ-001 Parameter MAX_IN_LEN, default 14: input vector length served by the ternary multiplier.
REQ-002 Parameter MAX_OUT_LEN, default 7: output rows per vector, legal range 1..8.
REQ-003 Parameter LOAD_BEATS, default 13: 16-bit beats per weight load (ceil(2*MAX_IN_LEN*MAX_OUT_LEN/16)), legal range 1..16.
REQ-004 Parameter PIPE_LAT, default 1: multiplier result latency in cycles, legal range 1..4.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_op  input  1  0 = load weights, 1 = multiply one vector.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-010 in_valid  input  1  16-bit data beat present on the shared input bus.
REQ-011 in_ready  output  1  beat consumed when in_valid and in_ready are both high.
REQ-012 load_en  output  1  weight-load strobe to the load unit.
REQ-013 load_idx  output  4  weight beat index.
REQ-014 mult_en  output  1  multiplier enable.
REQ-015 row  output  3  multiplier row select.
REQ-016 out_valid  output  1  uo_out result row valid.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse when a multiply command is rejected.
REQ-020 weights_ok  output  1  a complete weight set is resident.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, MWAIT, MULT and DRAIN.
REQ-022 IDLE: cmd_ready=1, in_ready=0; an accepted op 0 goes to LOAD with load_idx=0 and weights_ok cleared.
REQ-023 IDLE: an accepted op 1 with weights_ok=1 goes to MWAIT; with weights_ok=0 it stays in IDLE and pulses err the next cycle.
REQ-024 LOAD: in_ready=1; load_en = in_valid (combinational); each beat increments load_idx; in_valid low stalls with load_idx held.
REQ-025 LOAD: the beat taken at load_idx=LOAD_BEATS-1 returns the FSM to IDLE, sets weights_ok and pulses done on the first IDLE cycle.
REQ-026 MWAIT: in_ready=1; the accepted vector beat moves the FSM to MULT with row=0.
REQ-027 MULT: mult_en=1 for exactly MAX_OUT_LEN consecutive cycles, no stalls, row stepping 0..MAX_OUT_LEN-1; then DRAIN.
REQ-028 DRAIN: PIPE_LAT cycles, then IDLE with a done pulse.
REQ-029 out_valid SHALL equal mult_en delayed by PIPE_LAT cycles, giving exactly MAX_OUT_LEN pulses per vector.
REQ-030 cmd_ready=0 outside IDLE, so commands offered while busy are neither lost nor accepted; in_ready=0 in IDLE, MULT and DRAIN.
REQ-031 row and load_idx SHALL hold their value outside MULT and LOAD respectively, and SHALL never exceed MAX_OUT_LEN-1 or LOAD_BEATS-1.

Reset
REQ-032 rst SHALL force IDLE, clear weights_ok, load_idx, row and the out_valid pipeline, and drive every strobe output low; cmd_ready reads 1 on the first cycle after rst deasserts.
REQ-033 rst asserted mid-LOAD or mid-MULT SHALL abort without a done pulse and leave weights_ok=0.

Configuration
REQ-034 With TERNARY_SCHED_PERF_EN defined: add output perf_cnt[15:0], a saturating count of completed multiply vectors, cleared by rst and held at 16'hFFFF once reached.
REQ-035 Without TERNARY_SCHED_PERF_EN: the perf_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-036 Package ternary_pkg SHALL hold the state enum, the cmd_op encodings (OP_LOAD, OP_MULT) and the default-parameter constants.
REQ-037 One sub-module, ternary_sched_vdly, SHALL implement the PIPE_LAT-deep valid delay line; everything else stays flat.

Verification
REQ-038 Multiply before any load -> err pulses once, done stays 0, the FSM stays in IDLE.
REQ-039 Load with in_valid continuously high -> load_en high for 13 cycles with load_idx 0..12, weights_ok=1 and done pulses on the following cycle.
REQ-040 Load with in_valid low on beats 4 and 9 -> still exactly 13 load_en pulses, load_idx held during the gaps, completion 2 cycles later than the continuous case.
REQ-041 Multiply after a load, PIPE_LAT=1 -> mult_en on 7 cycles with row 0..6, out_valid on 7 cycles shifted by 1, done on the cycle after the DRAIN state.
REQ-042 cmd_valid held high during a MULT -> not accepted until IDLE; then a back-to-back second multiply completes correctly.
REQ-043 rst at row=3 -> IDLE, weights_ok=0, no done pulse; a following multiply raises err.
